// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline control unit: FSM states and the control bundle.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LOAD_USE = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_MEM_WAIT = 2'd3
  } pc_state_e;

  typedef struct packed {
    logic stall_fe;
    logic stall_de;
    logic stall_ex;
    logic bubble_ex;
    logic flush_fe_de;
  } ctrl_t;

  // A slot counter at 1 (or 0) is serving its final cycle.
  function automatic logic last_slot(input logic [2:0] cnt);
    return cnt <= 3'd1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_defs.sv
// State encodings of pipe_ctrl for files that prefer macros over the package enum.
// Values must stay in step with pc_state_e in pipe_ctrl_pkg.
`ifndef PIPE_CTRL_DEFS_V
`define PIPE_CTRL_DEFS_V
`define PC_RUN      2'd0
`define PC_LOAD_USE 2'd1
`define PC_FLUSH    2'd2
`define PC_MEM_WAIT 2'd3
`endif

// File: rtl/pipe_ctrl_lu_detect.sv
// Load-use hazard comparator: decode reads the register a load in exec is writing.
// Purely combinational so decode can reuse it for its own forwarding checks.
module lu_detect (
  input  logic       ex_valid,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  input  logic       de_valid,
  input  logic [4:0] de_rs1,
  input  logic [4:0] de_rs2,
  input  logic       de_use_rs1,
  input  logic       de_use_rs2,
  output logic       hit
);

  logic src_match;

  assign src_match = (de_use_rs1 && (de_rs1 == ex_rd)) ||
                     (de_use_rs2 && (de_rs2 == ex_rd));

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign hit = ex_valid && ex_is_load && (ex_rd != 5'd0) && de_valid && src_match;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing for the rv32i core: load-use stalls, redirect flushes, memory waits.
// Optional PIPE_CTRL_PERF_EN adds stall-cycle and redirect performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_LAT     = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       de_valid,
  input  logic [4:0] de_rs1,
  input  logic [4:0] de_rs2,
  input  logic       de_use_rs1,
  input  logic       de_use_rs2,
  input  logic       ex_valid,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  input  logic       ex_redirect,
  input  logic       mem_busy,
  output logic       stall_fe,
  output logic       stall_de,
  output logic       stall_ex,
  output logic       bubble_ex,
  output logic       flush_fe_de,
  output logic [1:0] state_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  input  logic        perf_clr,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam logic [2:0] LL_LOAD = 3'(LOAD_LAT - 1);
  localparam logic [2:0] FC_LOAD = 3'(FLUSH_CYCLES - 1);

  pc_state_e  state, next_state;
  logic [2:0] cnt, cnt_n;
  logic       saved_lu, saved_lu_n;
  logic       lu_hit, redir, accept;
  ctrl_t      ctl;

  lu_detect u_lu_detect (
    .ex_valid   (ex_valid),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .de_valid   (de_valid),
    .de_rs1     (de_rs1),
    .de_rs2     (de_rs2),
    .de_use_rs1 (de_use_rs1),
    .de_use_rs2 (de_use_rs2),
    .hit        (lu_hit)
  );

  // Exec keeps a redirect asserted until memory is free to accept it.
  assign redir = ex_redirect && !mem_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      cnt      <= 3'd0;
      saved_lu <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= cnt_n;
      saved_lu <= saved_lu_n;
    end
  end

  always_comb begin
    ctl        = '0;
    next_state = state;
    cnt_n      = cnt;
    saved_lu_n = saved_lu;
    accept     = 1'b0;
    if (redir) begin
      // Highest priority from any state; in FLUSH this reloads the slot count.
      accept          = 1'b1;
      ctl.flush_fe_de = 1'b1;
      ctl.bubble_ex   = 1'b1;
      cnt_n           = FC_LOAD;
      if (FLUSH_CYCLES > 1) next_state = ST_FLUSH;
      else                  next_state = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_busy) begin
            ctl.stall_fe = 1'b1;
            ctl.stall_de = 1'b1;
            saved_lu_n   = 1'b0;
            next_state   = ST_MEM_WAIT;
          end else if (lu_hit) begin
            ctl.stall_fe  = 1'b1;
            ctl.stall_de  = 1'b1;
            ctl.bubble_ex = 1'b1;
            cnt_n         = LL_LOAD;
            if (LOAD_LAT > 1) next_state = ST_LOAD_USE;
            else              next_state = ST_RUN;
          end
        end
        ST_LOAD_USE: begin
          ctl.stall_fe = 1'b1;
          ctl.stall_de = 1'b1;
          if (mem_busy) begin
            // No bubble this cycle: the remaining bubble count is frozen.
            saved_lu_n = 1'b1;
            next_state = ST_MEM_WAIT;
          end else begin
            ctl.bubble_ex = 1'b1;
            if (last_slot(cnt)) begin
              cnt_n      = 3'd0;
              next_state = ST_RUN;
            end else begin
              cnt_n = cnt - 3'd1;
            end
          end
        end
        ST_FLUSH: begin
          ctl.flush_fe_de = 1'b1;
          ctl.bubble_ex   = 1'b1;
          if (last_slot(cnt)) begin
            cnt_n      = 3'd0;
            next_state = ST_RUN;
          end else begin
            cnt_n = cnt - 3'd1;
          end
        end
        default: begin
          ctl.stall_fe = 1'b1;
          ctl.stall_de = 1'b1;
          if (!mem_busy) begin
            if (saved_lu) next_state = ST_LOAD_USE;
            else          next_state = ST_RUN;
          end
        end
      endcase
    end
    ctl.stall_ex = mem_busy;
  end

  assign stall_fe    = rst_n && ctl.stall_fe;
  assign stall_de    = rst_n && ctl.stall_de;
  assign stall_ex    = rst_n && ctl.stall_ex;
  assign bubble_ex   = rst_n && ctl.bubble_ex;
  assign flush_fe_de = rst_n && ctl.flush_fe_de;
  assign state_o     = rst_n ? state : ST_RUN;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cyc <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else if (perf_clr) begin
      perf_stall_cyc <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (stall_de) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (accept)   perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
